change_frame_sender: RTL and testbench

- Multi-channel successor to the single-byte change-detect sender.
- Watches CHANNELS input words of DATA_W bits each and detects words that differ from the last value sent for that channel.
- Queues one {channel, value} record per change in a small FIFO.
- Serialises each record into a byte frame (optional header, then data bytes MSB-first) on a valid/ready byte stream feeding the UART transmitter.
- Sits between the data sources and the UART TX.

---
 rtl/change_frame_sender_pkg.sv | 27 ++
 rtl/change_frame_sender_fifo.sv | 69 ++++++
 rtl/change_frame_sender.sv | 223 ++++++++++++++++++++++
 tb/tb_change_frame_sender.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_frame_sender_pkg.sv
// Shared definitions for the change-detect frame sender.
// Contents:
//   state_t     - byte serialiser FSM states
//   HDR_MARK    - top two bits of every header byte
//   HDR_CH_W    - channel field width inside the header byte
//   clog2Min1() - ceil(log2(n)) floored at 1, so one-entry sizes still get a bit
//   makeHeader()- builds {HDR_MARK, 1'b0, channel[4:0]}
package change_frame_sender_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] HDR_MARK = 2'b10;
    localparam int         HDR_CH_W = 5;

    function automatic int clog2Min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] makeHeader(input logic [HDR_CH_W-1:0] ch);
        return {HDR_MARK, 1'b0, ch};
    endfunction

endpackage

// File: rtl/change_frame_sender_fifo.sv
// Synchronous first-word-fall-through FIFO used to queue {channel, value}
// records between the change arbiter and the byte serialiser.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset (empties FIFO)
//   i_push, i_wrData - write request and record
//   i_pop            - read request; o_rdData already shows the head record
//   o_full, o_empty  - occupancy flags
//   o_level          - number of stored records, 0..DEPTH
// A push while full is accepted when a pop happens at the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wrData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdData,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_level  = r_count;
    assign o_rdData = r_mem[r_rdPtr];

    // A pop frees the slot at the same edge, so a full FIFO can still accept
    // a push when it is being read.
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    // Storage carries no reset; only pointers and count define the contents.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_doPush} - {{AW{1'b0}}, w_doPop};
        end
    end

endmodule

// File: rtl/change_frame_sender.sv
// Multi-channel change-detect frame sender. Watches CHANNELS words of DATA_W
// bits, queues one {channel, value} record per detected change and
// serialises each record as a byte frame (optional header, then data bytes
// MSB-first) on a valid/ready stream towards the UART transmitter.
// Ports:
//   uart_clk   - sole clock
//   rst        - asynchronous active-high reset
//   data_in    - channel c at bits [c*DATA_W +: DATA_W], sampled every edge
//   resend     - one-cycle pulse, forces every channel to be re-sent once
//   tx_data    - byte towards UART TX
//   tx_valid   - tx_data is valid
//   tx_ready   - UART TX accepts the byte
//   fifo_level - queued records, 0..FIFO_DEPTH
//   leds       - low byte of the most recently queued value
// HEADER_EN = 0 only makes sense with a single channel (frames carry no id).
module change_frame_sender
    import change_frame_sender_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int HEADER_EN  = 1
) (
    input  logic                          uart_clk,
    input  logic                          rst,
    input  logic [CHANNELS*DATA_W-1:0]    data_in,
    input  logic                          resend,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    leds
);

    localparam int CH_W   = clog2Min1(CHANNELS);
    localparam int REC_W  = CH_W + DATA_W;
    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = clog2Min1(NBYTES);

    logic [DATA_W-1:0]   r_lastSent [CHANNELS];
    logic [CHANNELS-1:0] r_dirty;
    logic [CH_W-1:0]     r_ptr;
    logic [7:0]          r_leds;

    state_t              r_state;
    logic [7:0]          r_txData;
    logic                r_txValid;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_value;

    state_t              w_nextState;
    logic [7:0]          w_nextTxData;
    logic                w_nextTxValid;
    logic [IDX_W-1:0]    w_nextIdx;
    logic [DATA_W-1:0]   w_nextValue;

    logic [CHANNELS-1:0] w_pending;
    logic                w_grantValid;
    logic [CH_W-1:0]     w_grantCh;
    logic [DATA_W-1:0]   w_grantData;
    logic                w_push;
    logic                w_pop;
    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic [REC_W-1:0]    w_popRec;
    logic [CH_W-1:0]     w_popCh;
    logic [DATA_W-1:0]   w_popVal;
    logic                w_handshake;

    // Selects data byte k of a value, byte 0 being the most significant.
    function automatic logic [7:0] byteOf(input logic [DATA_W-1:0] v,
                                          input logic [IDX_W-1:0]  k);
        logic [DATA_W-1:0] s;
        s = v >> (8 * (NBYTES - 1 - int'(k)));
        return s[7:0];
    endfunction

    // A channel needs sending when its input differs from what was last
    // queued for it, or a resend request has marked it dirty.
    always_comb begin
        w_pending = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_pending[c] = (data_in[c*DATA_W +: DATA_W] != r_lastSent[c]) | r_dirty[c];
        end
    end

    // Round-robin search starting at r_ptr; the first pending channel found wins.
    always_comb begin
        int idx;
        w_grantValid = 1'b0;
        w_grantCh    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_grantValid && w_pending[idx]) begin
                w_grantValid = 1'b1;
                w_grantCh    = CH_W'(idx);
            end
        end
    end

    // While the FIFO is full the grant is withheld and the channel stays
    // pending, so whatever value it holds once space frees is what gets sent.
    assign w_grantData = data_in[int'(w_grantCh)*DATA_W +: DATA_W];
    assign w_push      = w_grantValid & (~w_fifoFull | w_pop);

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (uart_clk),
        .i_rst    (rst),
        .i_push   (w_push),
        .i_wrData ({w_grantCh, w_grantData}),
        .i_pop    (w_pop),
        .o_rdData (w_popRec),
        .o_full   (w_fifoFull),
        .o_empty  (w_fifoEmpty),
        .o_level  (fifo_level)
    );

    assign w_popCh  = w_popRec[REC_W-1 -: CH_W];
    assign w_popVal = w_popRec[DATA_W-1:0];

    // Change-tracking state. The resend assignment comes last so that it
    // overrides the dirty clear of a channel granted on the same edge.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_lastSent[c] <= '0;
            end
            r_dirty <= '0;
            r_ptr   <= '0;
            r_leds  <= '0;
        end else begin
            if (w_push) begin
                r_lastSent[w_grantCh] <= w_grantData;
                r_dirty[w_grantCh]    <= 1'b0;
                r_ptr                 <= (w_grantCh == CH_W'(CHANNELS - 1)) ? '0 : w_grantCh + 1'b1;
                r_leds                <= w_grantData[7:0];
            end
            if (resend) begin
                r_dirty <= '1;
            end
        end
    end

    assign w_handshake = r_txValid & tx_ready;

    // Serialiser next-state logic. tx_data only changes on a handshake or
    // when a new record is popped, which keeps it stable under backpressure.
    always_comb begin
        w_nextState   = r_state;
        w_nextTxData  = r_txData;
        w_nextTxValid = r_txValid;
        w_nextIdx     = r_idx;
        w_nextValue   = r_value;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop         = 1'b1;
                    w_nextValue   = w_popVal;
                    w_nextTxValid = 1'b1;
                    w_nextIdx     = '0;
                    if (HEADER_EN != 0) begin
                        w_nextTxData = makeHeader(HDR_CH_W'(w_popCh));
                        w_nextState  = HDR;
                    end else begin
                        w_nextTxData = byteOf(w_popVal, '0);
                        w_nextState  = DATA;
                    end
                end
            end
            HDR: begin
                if (w_handshake) begin
                    w_nextTxData = byteOf(r_value, '0);
                    w_nextIdx    = '0;
                    w_nextState  = DATA;
                end
            end
            DATA: begin
                if (w_handshake) begin
                    if (r_idx == IDX_W'(NBYTES - 1)) begin
                        w_nextTxValid = 1'b0;
                        w_nextState   = IDLE;
                    end else begin
                        w_nextIdx    = r_idx + 1'b1;
                        w_nextTxData = byteOf(r_value, r_idx + 1'b1);
                    end
                end
            end
            default: begin
                w_nextTxValid = 1'b0;
                w_nextState   = IDLE;
            end
        endcase
    end

    // Serialiser registers; a reset abandons any frame in flight.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_txData  <= '0;
            r_txValid <= 1'b0;
            r_idx     <= '0;
            r_value   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_txData  <= w_nextTxData;
            r_txValid <= w_nextTxValid;
            r_idx     <= w_nextIdx;
            r_value   <= w_nextValue;
        end
    end

    assign tx_data  = r_txData;
    assign tx_valid = r_txValid;
    assign leds     = r_leds;

endmodule

// File: tb/tb_change_frame_sender.sv
// Directed bench for change_frame_sender. Instance A uses the default
// parameters; instance B uses 16-bit words and a two-entry FIFO.
module tb_change_frame_sender;

    logic uart_clk = 1'b0;
    logic rst;

    // Free-running clock, 10 time units per period.
    always #5 uart_clk = ~uart_clk;

    logic [31:0] dataA;
    logic        resendA;
    logic        readyA;
    logic [7:0]  txDataA;
    logic        txValidA;
    logic [3:0]  levelA;
    logic [7:0]  ledsA;

    logic [63:0] dataB;
    logic        resendB;
    logic        readyB;
    logic [7:0]  txDataB;
    logic        txValidB;
    logic [1:0]  levelB;
    logic [7:0]  ledsB;

    change_frame_sender dutA (
        .uart_clk   (uart_clk),
        .rst        (rst),
        .data_in    (dataA),
        .resend     (resendA),
        .tx_data    (txDataA),
        .tx_valid   (txValidA),
        .tx_ready   (readyA),
        .fifo_level (levelA),
        .leds       (ledsA)
    );

    change_frame_sender #(
        .DATA_W     (16),
        .CHANNELS   (4),
        .FIFO_DEPTH (2),
        .HEADER_EN  (1)
    ) dutB (
        .uart_clk   (uart_clk),
        .rst        (rst),
        .data_in    (dataB),
        .resend     (resendB),
        .tx_data    (txDataB),
        .tx_valid   (txValidB),
        .tx_ready   (readyB),
        .fifo_level (levelB),
        .leds       (ledsB)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] gotA[$];
    logic [7:0] gotB[$];
    logic [7:0] expA[$];
    logic [7:0] expB[$];

    logic       stallA = 1'b0;
    logic       stallB = 1'b0;
    logic [7:0] holdA  = 8'h00;
    logic [7:0] holdB  = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Advances the stimulus by a number of clock cycles, leaving time just
    // past the rising edge so inputs and samples sit away from it.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    // Compares collected bytes of one instance with the expected frame list,
    // then clears both lists for the next step.
    task automatic checkFrames(input int which, input string tag);
        if (which == 0) begin
            checkOutput({tag, " count"}, gotA.size(), expA.size());
            for (int i = 0; i < expA.size(); i++) begin
                checkOutput($sformatf("%s byte%0d", tag, i),
                            (i < gotA.size()) ? {24'h0, gotA[i]} : 32'hFFFF_FFFF, expA[i]);
            end
            gotA.delete();
            expA.delete();
        end else begin
            checkOutput({tag, " count"}, gotB.size(), expB.size());
            for (int i = 0; i < expB.size(); i++) begin
                checkOutput($sformatf("%s byte%0d", tag, i),
                            (i < gotB.size()) ? {24'h0, gotB[i]} : 32'hFFFF_FFFF, expB[i]);
            end
            gotB.delete();
            expB.delete();
        end
    endtask

    // Byte monitor on the falling edge: a byte with valid and ready here is
    // transferred at the next rising edge. A stalled byte must still be
    // present, unchanged, one cycle later.
    always @(negedge uart_clk) begin
        if (rst) begin
            stallA = 1'b0;
            stallB = 1'b0;
        end else begin
            if (stallA) begin
                checkOutput("A stall valid", txValidA, 1);
                checkOutput("A stall data", txDataA, holdA);
            end
            if (stallB) begin
                checkOutput("B stall valid", txValidB, 1);
                checkOutput("B stall data", txDataB, holdB);
            end
            if (txValidA && readyA) gotA.push_back(txDataA);
            if (txValidB && readyB) gotB.push_back(txDataB);
            stallA = txValidA && !readyA;
            stallB = txValidB && !readyB;
            holdA  = txDataA;
            holdB  = txDataB;
        end
    end

    initial begin
        rst     = 1'b1;
        dataA   = '0;
        dataB   = '0;
        resendA = 1'b0;
        resendB = 1'b0;
        readyA  = 1'b0;
        readyB  = 1'b0;
        applyStimulus(3);

        checkOutput("reset A valid", txValidA, 0);
        checkOutput("reset A data", txDataA, 0);
        checkOutput("reset A level", levelA, 0);
        checkOutput("reset A leds", ledsA, 0);
        checkOutput("reset B valid", txValidB, 0);
        checkOutput("reset B level", levelB, 0);

        rst = 1'b0;
        applyStimulus(1);
        checkOutput("idle A valid", txValidA, 0);
        checkOutput("idle A level", levelA, 0);

        $display("[TB] single change on channel 2");
        readyA = 1'b1;
        dataA[23:16] = 8'h5A;
        applyStimulus(1);
        checkOutput("single level after push", levelA, 1);
        checkOutput("single leds", ledsA, 8'h5A);
        checkOutput("single valid one edge", txValidA, 0);
        applyStimulus(1);
        checkOutput("single valid two edges", txValidA, 1);
        checkOutput("single header", txDataA, 8'h82);
        checkOutput("single level after pop", levelA, 0);
        applyStimulus(4);
        expA = '{8'h82, 8'h5A};
        checkFrames(0, "single");

        $display("[TB] four channels change together, pointer at 0");
        readyA = 1'b0;
        dataA[31:24] = 8'h99;
        applyStimulus(2);
        checkOutput("burst stalled valid", txValidA, 1);
        checkOutput("burst stalled header", txDataA, 8'h83);
        dataA = 32'h44332211;
        applyStimulus(4);
        checkOutput("burst level peak", levelA, 4);
        checkOutput("burst held header", txDataA, 8'h83);
        applyStimulus(1);
        checkOutput("burst level steady", levelA, 4);
        checkOutput("burst leds", ledsA, 8'h44);
        readyA = 1'b1;
        applyStimulus(18);
        expA = '{8'h83, 8'h99, 8'h80, 8'h11, 8'h81, 8'h22, 8'h82, 8'h33, 8'h83, 8'h44};
        checkFrames(0, "burst");
        checkOutput("burst drained level", levelA, 0);

        $display("[TB] backpressure with a two-entry FIFO");
        readyB = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            dataB[15:0] = 16'(i);
            applyStimulus(1);
        end
        checkOutput("bp level saturated", levelB, 2);
        checkOutput("bp valid", txValidB, 1);
        checkOutput("bp header", txDataB, 8'h80);
        checkOutput("bp leds", ledsB, 8'h03);
        applyStimulus(2);
        checkOutput("bp level still", levelB, 2);
        readyB = 1'b1;
        applyStimulus(20);
        expB = '{8'h80, 8'h00, 8'h01, 8'h80, 8'h00, 8'h02,
                 8'h80, 8'h00, 8'h03, 8'h80, 8'h00, 8'h0A};
        checkFrames(1, "bp");
        checkOutput("bp final leds", ledsB, 8'h0A);

        $display("[TB] ready asserted one cycle in three");
        dataA[15:8]  = 8'hA1;
        dataA[23:16] = 8'hB2;
        for (int i = 0; i < 30; i++) begin
            readyA = (i % 3 == 0);
            applyStimulus(1);
        end
        readyA = 1'b1;
        applyStimulus(4);
        expA = '{8'h81, 8'hA1, 8'h82, 8'hB2};
        checkFrames(0, "toggle");

        $display("[TB] resend with unchanged inputs");
        resendA = 1'b1;
        applyStimulus(1);
        resendA = 1'b0;
        applyStimulus(16);
        expA = '{8'h83, 8'h44, 8'h80, 8'h11, 8'h81, 8'hA1, 8'h82, 8'hB2};
        checkFrames(0, "resend");

        $display("[TB] resend together with a channel 1 grant");
        dataA[15:8] = 8'hC1;
        resendA = 1'b1;
        applyStimulus(1);
        resendA = 1'b0;
        applyStimulus(20);
        expA = '{8'h81, 8'hC1, 8'h82, 8'hB2, 8'h83, 8'h44,
                 8'h80, 8'h11, 8'h81, 8'hC1};
        checkFrames(0, "resend grant");

        $display("[TB] 16-bit word frame");
        dataB[15:0] = 16'hBEEF;
        applyStimulus(8);
        expB = '{8'h80, 8'hBE, 8'hEF};
        checkFrames(1, "wide");
        checkOutput("wide leds", ledsB, 8'hEF);

        $display("[TB] reset in the middle of a frame");
        readyB = 1'b0;
        dataB[31:16] = 16'h1234;
        dataB[47:32] = 16'h5678;
        dataB[63:48] = 16'h9ABC;
        applyStimulus(3);
        checkOutput("midframe level", levelB, 2);
        checkOutput("midframe valid", txValidB, 1);
        checkOutput("midframe header", txDataB, 8'h81);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset valid", txValidB, 0);
        checkOutput("async reset level", levelB, 0);
        checkOutput("async reset leds", ledsB, 0);
        checkOutput("async reset A valid", txValidA, 0);
        dataA = '0;
        dataB = '0;
        applyStimulus(2);
        rst = 1'b0;
        readyB = 1'b1;
        applyStimulus(6);
        checkFrames(1, "no resume");
        checkOutput("no resume valid", txValidB, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
